// File: rtl/fpu_norm_lshift_pkg.sv
// fpu_norm_lshift shared definitions
// Lead-0 count width helper and stage occupancy encoding.
package fpu_norm_lshift_pkg;

  // Lead-0 count spans 0..w, so it needs one bit above log2(w).
  function automatic int lz_width(input int w);
    return $clog2(w) + 1;
  endfunction

  typedef enum logic {
    STG_EMPTY = 1'b0,
    STG_FULL  = 1'b1
  } stg_vld_e;

endpackage

// File: rtl/fpu_norm_lshift_lead0_cnt.sv
// fpu_norm_lead0_cnt: combinational lead-0 counter
// Ports: mant_i (MANT_W) in, lz_o (log2(MANT_W)+1) out, 0..MANT_W.
module fpu_norm_lead0_cnt
  import fpu_norm_lshift_pkg::*;
#(
  parameter int MANT_W = 64
) (
  input  logic [MANT_W-1:0]           mant_i,
  output logic [lz_width(MANT_W)-1:0] lz_o
);

  localparam int G    = MANT_W / 4;
  localparam int LV   = $clog2(G);
  localparam int CW   = $clog2(MANT_W);
  localparam int LZ_W = lz_width(MANT_W);

  logic [CW-1:0] cnt [LV+1][G];
  logic          zg  [LV+1][G];
  logic [3:0]    nib;

  always_comb begin
    nib = '0;
    for (int l = 0; l <= LV; l++) begin
      for (int n = 0; n < G; n++) begin
        cnt[l][n] = '0;
        zg[l][n]  = 1'b0;
      end
    end
    // Group 0 is the most significant nibble.
    for (int g = 0; g < G; g++) begin
      nib = mant_i[MANT_W-1-4*g -: 4];
      zg[0][g] = (nib == 4'h0);
      if (nib[3])      cnt[0][g] = CW'(0);
      else if (nib[2]) cnt[0][g] = CW'(1);
      else if (nib[1]) cnt[0][g] = CW'(2);
      else             cnt[0][g] = CW'(3);
    end
    // An all-zero upper half adds its full width to the lower count;
    // the lower count is below that width, so OR is an add.
    for (int l = 1; l <= LV; l++) begin
      for (int n = 0; n < (G >> l); n++) begin
        zg[l][n] = zg[l-1][2*n] & zg[l-1][2*n+1];
        if (zg[l-1][2*n])
          cnt[l][n] = cnt[l-1][2*n+1] | (CW'(1) << (l + 1));
        else
          cnt[l][n] = cnt[l-1][2*n];
      end
    end
    lz_o = zg[LV][0] ? LZ_W'(MANT_W)
                     : {1'b0, cnt[LV][0]};
  end

endmodule

// File: rtl/fpu_norm_lshift.sv
// fpu_norm_lshift: 2-stage mantissa normalizer, valid/ready both ends
// In: rclk, reset, in_vld/in_mant/in_exp/in_tag, out_rdy. Out: in_rdy,
// out_vld/out_mant/out_exp/out_lz/out_zero/out_unf/out_tag.
// Macro FPU_NORM_EXP_CLAMP_EN: clamp shift to exponent (denormal result).
module fpu_norm_lshift
  import fpu_norm_lshift_pkg::*;
#(
  parameter int MANT_W = 64,
  parameter int EXP_W  = 13,
  parameter int TAG_W  = 4
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [MANT_W-1:0]     in_mant,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [MANT_W-1:0]     out_mant,
  output logic [EXP_W-1:0]      out_exp,
  output logic [$clog2(MANT_W):0] out_lz,
  output logic                  out_zero,
  output logic                  out_unf,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int LZ_W = lz_width(MANT_W);

  stg_vld_e s1_st_q, s1_st_d;
  stg_vld_e s2_st_q, s2_st_d;
  logic s1_vld, s2_vld;
  logic s1_ld, s2_ld;

  logic [MANT_W-1:0] s1_mant_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic [MANT_W-1:0] s2_mant_q, mant_d;
  logic [EXP_W-1:0]  s2_exp_q, exp_d;
  logic [LZ_W-1:0]   s2_lz_q;
  logic              s2_zero_q, zero_d;
  logic              s2_unf_q, unf_d;
  logic [TAG_W-1:0]  s2_tag_q;

  logic [LZ_W-1:0]   lz, sh;
  logic [EXP_W:0]    dif_e;
  logic [MANT_W-1:0] m;

  fpu_norm_lead0_cnt #(
    .MANT_W (MANT_W)
  ) u_lz (
    .mant_i (s1_mant_q),
    .lz_o   (lz)
  );

  assign s1_vld = (s1_st_q == STG_FULL);
  assign s2_vld = (s2_st_q == STG_FULL);
  assign in_rdy = !s1_vld | !s2_vld | out_rdy;
  assign s2_ld  = s1_vld & (!s2_vld | out_rdy);
  assign s1_ld  = in_vld & in_rdy;

  always_comb begin
    s1_st_d = s1_st_q;
    if (s1_ld)      s1_st_d = STG_FULL;
    else if (s2_ld) s1_st_d = STG_EMPTY;
    s2_st_d = s2_st_q;
    if (s2_ld)        s2_st_d = STG_FULL;
    else if (out_rdy) s2_st_d = STG_EMPTY;
  end

  // Borrow of exp - lz flags lz > exp, which is
  // both the underflow and the clamp condition.
  always_comb begin
    zero_d = (lz == LZ_W'(MANT_W));
    dif_e  = {1'b0, s1_exp_q} - (EXP_W+1)'(lz);
    unf_d  = dif_e[EXP_W];
    exp_d  = dif_e[EXP_W-1:0];
    sh     = lz;
`ifdef FPU_NORM_EXP_CLAMP_EN
    if (unf_d) begin
      sh    = LZ_W'(s1_exp_q);
      exp_d = '0;
    end
`endif
    if (zero_d) begin
      exp_d = '0;
      unf_d = 1'b0;
    end
    m = s1_mant_q;
    for (int k = 0; k < LZ_W; k++) begin
      if (sh[k]) m = m << (1 << k);
    end
    mant_d = m;
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      s1_st_q   <= STG_EMPTY;
      s2_st_q   <= STG_EMPTY;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_tag_q  <= '0;
      s2_mant_q <= '0;
      s2_exp_q  <= '0;
      s2_lz_q   <= '0;
      s2_zero_q <= 1'b0;
      s2_unf_q  <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s1_st_q <= s1_st_d;
      s2_st_q <= s2_st_d;
      if (s1_ld) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_tag_q  <= in_tag;
      end
      if (s2_ld) begin
        s2_mant_q <= mant_d;
        s2_exp_q  <= exp_d;
        s2_lz_q   <= lz;
        s2_zero_q <= zero_d;
        s2_unf_q  <= unf_d;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_vld  = s2_vld;
  assign out_mant = s2_mant_q;
  assign out_exp  = s2_exp_q;
  assign out_lz   = s2_lz_q;
  assign out_zero = s2_zero_q;
  assign out_unf  = s2_unf_q;
  assign out_tag  = s2_tag_q;

endmodule

// File: tb/tb_fpu_norm_lshift.sv
// tb_fpu_norm_lshift: scoreboard bench for fpu_norm_lshift
// Random and directed beats checked against a behavioural model.
module tb_fpu_norm_lshift;

  localparam int MW = 64;
  localparam int EW = 13;
  localparam int TW = 4;
  localparam int LW = 7;

  logic          rclk = 1'b0;
  logic          reset = 1'b1;
  logic          in_vld = 1'b0;
  logic          in_rdy;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [LW-1:0] out_lz;
  logic          out_zero;
  logic          out_unf;
  logic [TW-1:0] out_tag;

  fpu_norm_lshift dut (
    .rclk     (rclk),
    .reset    (reset),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_mant  (in_mant),
    .in_exp   (in_exp),
    .in_tag   (in_tag),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_mant (out_mant),
    .out_exp  (out_exp),
    .out_lz   (out_lz),
    .out_zero (out_zero),
    .out_unf  (out_unf),
    .out_tag  (out_tag)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] e;
    logic [LW-1:0] lz;
    logic          zero;
    logic          unf;
    logic [TW-1:0] tag;
    int            acc;
  } beat_t;

  beat_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit lat_chk = 1'b0;

  always @(posedge rclk) cyc <= cyc + 1;

  function automatic beat_t model(input logic [MW-1:0] m,
                                  input logic [EW-1:0] e,
                                  input logic [TW-1:0] t);
    beat_t b;
    int lz, sh, d, ei;
    lz = MW;
    ei = int'(e);
    for (int i = MW - 1; i >= 0; i--) begin
      if (m[i]) begin
        lz = MW - 1 - i;
        break;
      end
    end
`ifdef FPU_NORM_EXP_CLAMP_EN
    sh = (lz < ei) ? lz : ei;
    d = ei - sh;
    b.unf = (lz > ei);
`else
    sh = lz;
    d = ei - lz;
    b.unf = (d < 0);
    if (d < 0) d = d + (1 << EW);
`endif
    b.mant = (sh >= MW) ? '0 : (m << sh);
    b.e = EW'(d);
    b.lz = LW'(lz);
    b.zero = (m == '0);
    b.tag = t;
    b.acc = cyc;
    if (b.zero) begin
      b.e = '0;
      b.unf = 1'b0;
      b.mant = '0;
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [MW-1:0] rnd_mant();
    logic [MW-1:0] r;
    r = {$urandom(), $urandom()};
    return r >> $urandom_range(0, MW);
  endfunction

  function automatic logic [EW-1:0] rnd_exp();
    if ($urandom_range(0, 1) == 1) return EW'($urandom_range(0, 80));
    return EW'($urandom_range(0, (1 << EW) - 1));
  endfunction

  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e,
                      input logic [TW-1:0] t, output int waits);
    waits = 0;
    @(posedge rclk); #1;
    in_vld = 1'b1;
    in_mant = m;
    in_exp = e;
    in_tag = t;
    forever begin
      @(negedge rclk);
      if (in_rdy) begin
        sbq.push_back(model(m, e, t));
        break;
      end
      waits++;
      if (waits > 500) begin
        chk("in_rdy_timeout", 64'(waits), 0);
        break;
      end
      @(posedge rclk); #1;
    end
  endtask

  task automatic idle();
    @(posedge rclk); #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge rclk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 0);
    repeat (2) @(negedge rclk);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_vld", 64'(out_vld), 0);
    chk("rst_in_rdy", 64'(in_rdy), 1);
    chk("rst_out_mant", out_mant, 0);
    chk("rst_out_exp", 64'(out_exp), 0);
    chk("rst_out_lz", 64'(out_lz), 0);
    chk("rst_out_zero", 64'(out_zero), 0);
    chk("rst_out_unf", 64'(out_unf), 0);
    chk("rst_out_tag", 64'(out_tag), 0);
  endtask

  initial begin
    forever begin
      @(posedge rclk); #1;
      case (rdy_mode)
        0: out_rdy = 1'b1;
        1: out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  initial begin
    logic hold;
    logic [MW-1:0] pm;
    logic [EW-1:0] pe;
    logic [LW-1:0] pl;
    logic [TW-1:0] pt;
    beat_t b;
    hold = 1'b0;
    pm = '0; pe = '0; pl = '0; pt = '0;
    forever begin
      @(negedge rclk);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        chk("hold_vld", 64'(out_vld), 1);
        chk("hold_mant", out_mant, pm);
        chk("hold_exp", 64'(out_exp), 64'(pe));
        chk("hold_lz", 64'(out_lz), 64'(pl));
        chk("hold_tag", 64'(out_tag), 64'(pt));
      end
      if (out_vld) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 64'(out_vld), 0);
        end else begin
          b = sbq[0];
          if (!hold && lat_chk)
            chk("latency", 64'(cyc - b.acc), 2);
          if (out_rdy) begin
            chk("mant", out_mant, b.mant);
            chk("exp", 64'(out_exp), 64'(b.e));
            chk("lz", 64'(out_lz), 64'(b.lz));
            chk("zero", 64'(out_zero), 64'(b.zero));
            chk("unf", 64'(out_unf), 64'(b.unf));
            chk("tag", 64'(out_tag), 64'(b.tag));
            void'(sbq.pop_front());
          end
        end
      end
      hold = out_vld & !out_rdy;
      pm = out_mant; pe = out_exp; pl = out_lz; pt = out_tag;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, acc;
    bit accepted;
    logic [MW-1:0] pm;
    logic [EW-1:0] pe;
    logic [TW-1:0] pt;

    reset = 1'b1;
    repeat (3) @(posedge rclk);
    #1 reset = 1'b0;
    @(negedge rclk);
    chk_reset_state();

    // Directed corner beats, no stalls
    rdy_mode = 0;
    lat_chk = 1'b1;
    send(64'h0000_0000_0000_00F0, 13'd100, 4'd1, w);
    send(64'h0000_0001_0000_0000, 13'd10, 4'd2, w);
    send(64'h0, 13'd500, 4'd7, w);
    send(64'h8000_0000_0000_0001, 13'd5, 4'd3, w);
    send(64'h1, 13'd0, 4'd4, w);
    send(64'h1, 13'd8191, 4'd5, w);
    send(64'h0000_0000_0000_0003, 13'd62, 4'd6, w);
    idle();
    drain();

    // Back-to-back streaming
    for (int t = 0; t < 8; t++) begin
      send(rnd_mant(), rnd_exp(), TW'(t), w);
      chk("stream_in_rdy", 64'(w), 0);
    end
    idle();
    drain();
    lat_chk = 1'b0;

    // Backpressure: consumer stalls while producer streams
    rdy_mode = 2;
    acc = 0;
    accepted = 1'b1;
    pm = '0; pe = '0; pt = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge rclk); #1;
      if (accepted) begin
        pm = rnd_mant();
        pe = rnd_exp();
        pt = TW'(8 + c);
        in_vld = 1'b1;
        in_mant = pm;
        in_exp = pe;
        in_tag = pt;
      end
      @(negedge rclk);
      accepted = in_rdy;
      if (in_rdy) begin
        sbq.push_back(model(pm, pe, pt));
        acc++;
      end
    end
    chk("bp_accepts", 64'(acc), 2);
    chk("bp_in_rdy", 64'(in_rdy), 0);
    rdy_mode = 0;
    if (!accepted) send(pm, pe, pt, w);
    idle();
    drain();

    // Random traffic with random consumer stalls
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(rnd_mant(), rnd_exp(), TW'($urandom_range(0, 15)), w);
    end
    idle();
    rdy_mode = 0;
    drain();

    // Reset with both stages full
    rdy_mode = 2;
    repeat (2) @(negedge rclk);
    send(rnd_mant(), rnd_exp(), 4'd9, w);
    send(rnd_mant(), rnd_exp(), 4'd10, w);
    @(posedge rclk); #1;
    in_vld = 1'b0;
    reset = 1'b1;
    sbq.delete();
    @(negedge rclk);
    chk("full_in_rdy", 64'(in_rdy), 0);
    @(posedge rclk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    @(negedge rclk);
    chk_reset_state();
    repeat (2) @(negedge rclk);
    lat_chk = 1'b1;
    send(64'h0000_0000_0000_00F0, 13'd100, 4'd11, w);
    idle();
    drain();
    lat_chk = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
